// File: rtl/div_unit.sv
// -----------------------------------------------------------------------------
// div_unit
// Multi-cycle radix-2 restoring divider for DIV / DIVU in the EX stage.
// Produces {remainder, quotient}; the remainder goes to HI, the quotient to LO.
// One quotient bit is resolved per cycle, MSB first, so a division takes
// WIDTH cycles in ON plus one cycle in END where the result is presented.
//
// State table:
//   IDLE    | waiting for start; operands are latched on the accepting edge
//   DIVZERO | divisor was zero; one cycle, result forced to 0
//   ON      | iterating, one quotient bit per cycle
//   END     | ready pulses for one cycle, divres valid
//
// Ports:
//   clk         in   system clock, rising edge
//   resetn      in   asynchronous active-low reset
//   start       in   division request, sampled only in IDLE
//   signed_div  in   1 = signed (DIV), 0 = unsigned (DIVU), sampled with start
//   opdata1     in   dividend
//   opdata2     in   divisor
//   annul       in   pipeline flush; aborts a division in ON / DIVZERO
//   divres      out  {remainder, quotient}, held until the next completion
//   ready       out  one-cycle pulse, divres valid
//   stall       out  combinational stall request to the hazard unit
// -----------------------------------------------------------------------------
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               start,
    input  logic               signed_div,
    input  logic [WIDTH-1:0]   opdata1,
    input  logic [WIDTH-1:0]   opdata2,
    input  logic               annul,
    output logic [2*WIDTH-1:0] divres,
    output logic               ready,
    output logic               stall
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
    localparam logic [WIDTH-1:0] ONE_W    = WIDTH'(1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_DIVZERO = 2'd1,
        S_ON      = 2'd2,
        S_END     = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_next;

    logic [WIDTH-1:0]   r_quot;      // dividend bits shift out the top, quotient bits shift in
    logic [WIDTH-1:0]   r_divisor;
    logic [WIDTH-1:0]   r_rem;
    logic [CW-1:0]      r_cnt;
    logic               r_sign_q;
    logic               r_sign_r;
    logic [2*WIDTH-1:0] r_divres;

    logic               w_accept;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_a_abs;
    logic [WIDTH-1:0]   w_b_abs;
    logic [WIDTH:0]     w_shift;
    logic [WIDTH:0]     w_diff;
    logic               w_qbit;
    logic [WIDTH-1:0]   w_rem_sel;
    logic [WIDTH-1:0]   w_quot_next;
    logic [WIDTH-1:0]   w_q_fix;
    logic [WIDTH-1:0]   w_r_fix;

    // annul has priority over a simultaneous start
    assign w_accept = start & ~annul;

    // Sign handling only applies to signed requests; the absolute value of the
    // most negative number wraps to itself, which is still correct unsigned.
    assign w_a_neg = signed_div & opdata1[WIDTH-1];
    assign w_b_neg = signed_div & opdata2[WIDTH-1];
    assign w_a_abs = w_a_neg ? (~opdata1 + ONE_W) : opdata1;
    assign w_b_abs = w_b_neg ? (~opdata2 + ONE_W) : opdata2;

    // Restoring step on a WIDTH+1 bit partial remainder; the top bit of the
    // difference is the borrow that decides restore vs. keep.
    assign w_shift     = {r_rem, r_quot[WIDTH-1]};
    assign w_diff      = w_shift - {1'b0, r_divisor};
    assign w_qbit      = ~w_diff[WIDTH];
    assign w_rem_sel   = w_qbit ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
    assign w_quot_next = {r_quot[WIDTH-2:0], w_qbit};

    // Truncation toward zero: quotient sign is a^b, remainder follows dividend
    assign w_q_fix = r_sign_q ? (~w_quot_next + ONE_W) : w_quot_next;
    assign w_r_fix = r_sign_r ? (~w_rem_sel + ONE_W)   : w_rem_sel;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        ready  = 1'b0;
        stall  = 1'b0;
        case (r_state)
            S_IDLE: begin
                stall = w_accept;
                if (w_accept) begin
                    w_next = (opdata2 == '0) ? S_DIVZERO : S_ON;
                end
            end
            S_DIVZERO: begin
                stall  = 1'b1;
                w_next = annul ? S_IDLE : S_END;
            end
            S_ON: begin
                stall = 1'b1;
                if (annul) begin
                    w_next = S_IDLE;
                end else if (r_cnt == CNT_LAST) begin
                    w_next = S_END;
                end
            end
            S_END: begin
                ready  = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_quot    <= '0;
            r_divisor <= '0;
            r_rem     <= '0;
            r_cnt     <= '0;
            r_sign_q  <= 1'b0;
            r_sign_r  <= 1'b0;
            r_divres  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept && (opdata2 != '0)) begin
                        r_quot    <= w_a_abs;
                        r_divisor <= w_b_abs;
                        r_rem     <= '0;
                        r_cnt     <= '0;
                        r_sign_q  <= w_a_neg ^ w_b_neg;
                        r_sign_r  <= w_a_neg;
                    end
                end
                S_ON: begin
                    if (!annul) begin
                        r_rem  <= w_rem_sel;
                        r_quot <= w_quot_next;
                        r_cnt  <= r_cnt + CNT_ONE;
                        if (r_cnt == CNT_LAST) begin
                            r_divres <= {w_r_fix, w_q_fix};
                        end
                    end
                end
                S_DIVZERO: begin
                    if (!annul) begin
                        r_divres <= '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign divres = r_divres;

endmodule

// File: tb/tb_div_unit.sv
module tb_div_unit;

    logic        clk        = 1'b0;
    logic        resetn     = 1'b0;
    logic        start      = 1'b0;
    logic        signed_div = 1'b0;
    logic        annul      = 1'b0;
    logic [31:0] opdata1    = '0;
    logic [31:0] opdata2    = '0;
    logic [63:0] divres;
    logic        ready;
    logic        stall;

    div_unit #(.WIDTH(32)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .signed_div (signed_div),
        .opdata1    (opdata1),
        .opdata2    (opdata2),
        .annul      (annul),
        .divres     (divres),
        .ready      (ready),
        .stall      (stall)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [63:0] res;
        int          issue;
        int          lat;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference: plain integer division, truncating toward zero. 64-bit
    // arithmetic keeps -2^31 / -1 well defined; its low 32 bits wrap as MIPS does.
    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                            input logic sgn);
        longint sa;
        longint sb;
        longint q;
        longint r;
        logic [31:0] uq;
        logic [31:0] ur;
        if (b == 32'd0) return 64'd0;
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = sa / sb;
            r  = sa % sb;
            return {r[31:0], q[31:0]};
        end
        uq = a / b;
        ur = a % b;
        return {ur, uq};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (resetn && ready) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_ready: got ready=1 divres=%h expected no result", divres);
                end else begin
                    e = sb_q.pop_front();
                    check("divres", divres, e.res);
                    check("latency", 64'(cyc - e.issue), 64'(e.lat));
                end
            end
        end
    endtask

    // Drive a request for one cycle (start asserted at this negedge).
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                         input logic push, input logic [63:0] exp);
        exp_t e;
        @(negedge clk);
        opdata1    = a;
        opdata2    = b;
        signed_div = sgn;
        start      = 1'b1;
        #1;
        check("stall_on_request", 64'(stall), 64'd1);
        if (push) begin
            e.res   = exp;
            e.issue = cyc;
            e.lat   = (b == 32'd0) ? 2 : 33;
            sb_q.push_back(e);
        end
    endtask

    // Drop start, scramble operands, optionally poke start mid-operation,
    // then wait (bounded) for ready while counting stall cycles.
    task automatic wait_done(input int exp_stall, input int poke_at);
        int  stall_cnt = 0;
        bit  seen      = 0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            if (i == poke_at) begin
                start      = 1'b1;
                opdata1    = $urandom;
                opdata2    = $urandom_range(1, 50);
                signed_div = ~signed_div;
            end else begin
                start   = 1'b0;
                opdata1 = $urandom;
                opdata2 = $urandom;
            end
            #1;
            if (ready) begin
                seen = 1;
                check("stall_low_at_ready", 64'(stall), 64'd0);
            end else if (stall) begin
                stall_cnt++;
            end
        end
        start = 1'b0;
        check("ready_seen", 64'(seen), 64'd1);
        check("stall_cycles", 64'(stall_cnt), 64'(exp_stall));
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            start   = 1'b0;
            opdata1 = $urandom;
            opdata2 = $urandom;
        end
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        logic        sgn;
        int          mode;

        fork
            monitor();
        join_none

        #1;
        check("reset_divres", divres, 64'd0);
        check("reset_ready", 64'(ready), 64'd0);
        check("reset_stall", 64'(stall), 64'd0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;

        // -7 / 2 signed
        issue(32'hFFFFFFF9, 32'd2, 1'b1, 1'b1, 64'hFFFFFFFF_FFFFFFFD);
        wait_done(32, -1);
        // 0xFFFFFFFF / 16 unsigned, then signed
        issue(32'hFFFFFFFF, 32'h10, 1'b0, 1'b1, 64'h0000000F_0FFFFFFF);
        wait_done(32, -1);
        issue(32'hFFFFFFFF, 32'h10, 1'b1, 1'b1, 64'hFFFFFFFF_00000000);
        wait_done(32, -1);
        // signed overflow
        issue(32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b1, 64'h00000000_80000000);
        wait_done(32, -1);
        // divide by zero, then 100/7
        issue(32'd1234, 32'd0, 1'b0, 1'b1, 64'd0);
        wait_done(1, -1);
        issue(32'd100, 32'd7, 1'b0, 1'b1, 64'h00000002_0000000E);
        wait_done(32, -1);

        // Annul mid-operation
        issue(32'd10, 32'd3, 1'b0, 1'b1, 64'h00000001_00000003);
        wait_done(32, -1);
        issue(32'd50, 32'd5, 1'b0, 1'b0, 64'd0);
        step(15);
        annul = 1'b1;
        @(negedge clk);
        annul = 1'b0;
        #1;
        check("annul_stall_low", 64'(stall), 64'd0);
        step(40);
        check("annul_divres_held", divres, 64'h00000001_00000003);

        // Annul in DIVZERO: no result, divres kept
        issue(32'd5, 32'd0, 1'b0, 1'b0, 64'd0);
        @(negedge clk);
        start = 1'b0;
        annul = 1'b1;
        @(negedge clk);
        annul = 1'b0;
        step(5);
        check("annul_divzero_held", divres, 64'h00000001_00000003);

        // start pulse while ON is ignored
        issue(32'd100, 32'd7, 1'b0, 1'b1, 64'h00000002_0000000E);
        wait_done(32, 6);
        step(40);

        // start with annul in IDLE: nothing begins
        @(negedge clk);
        opdata1 = 32'd77;
        opdata2 = 32'd0;
        start   = 1'b1;
        annul   = 1'b1;
        #1;
        check("start_annul_stall", 64'(stall), 64'd0);
        @(negedge clk);
        start = 1'b0;
        annul = 1'b0;
        #1;
        check("start_annul_idle", 64'(stall), 64'd0);
        step(5);
        check("start_annul_divres", divres, 64'h00000002_0000000E);

        // Asynchronous reset mid-operation
        issue(32'd50, 32'd5, 1'b1, 1'b0, 64'd0);
        step(20);
        #2;
        resetn = 1'b0;
        #1;
        check("rst_divres", divres, 64'd0);
        check("rst_ready", 64'(ready), 64'd0);
        check("rst_stall", 64'(stall), 64'd0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        issue(32'd9, 32'd4, 1'b0, 1'b1, 64'h00000001_00000002);
        wait_done(32, -1);

        // Randomized operations against the reference model
        for (int n = 0; n < 40; n++) begin
            a    = $urandom;
            mode = $urandom_range(0, 9);
            case (mode)
                0:       b = 32'd0;
                1, 2, 3: b = $urandom_range(1, 20);
                4:       b = 32'hFFFFFFFF;
                5:       b = 32'hFFFFFFF0 | 32'($urandom_range(0, 15));
                default: b = $urandom;
            endcase
            if ($urandom_range(0, 7) == 0) a = 32'h80000000;
            sgn = 1'($urandom_range(0, 1));
            issue(a, b, sgn, 1'b1, ref_div(a, b, sgn));
            wait_done((b == 32'd0) ? 1 : 32, -1);
        end

        step(5);
        check("scoreboard_drained", 64'(sb_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no completion expected finish");
        $fatal(1, "timeout");
    end

endmodule
